// File: rtl/parity_pkg.sv
// Shared types and helpers for the serial parity receiver: FSM states,
// parity-sense encodings and the parity-mismatch helper.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // acc is the XOR of all data bits; a set result means the frame is bad
  function automatic logic parity_mismatch(input logic acc, input logic par_bit, input logic sense);
    return acc ^ par_bit ^ sense;
  endfunction

endpackage

// File: rtl/parity_checker_rx_if.sv
// Bit-stream input and valid/ready word output of the parity receiver.
// master = stream source / word consumer, slave = the receiver.
interface parity_checker_rx_if #(parameter int width = 8);
  logic             sof;
  logic             bit_valid;
  logic             bit_in;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] out_data;
  logic             out_err;

  modport master (
    output sof, bit_valid, bit_in, out_ready,
    input  out_valid, out_data, out_err
  );

  modport slave (
    input  sof, bit_valid, bit_in, out_ready,
    output out_valid, out_data, out_err
  );
endinterface

// File: rtl/parity_checker_rx.sv
// Deserialises sof-framed bit streams (LSB first + parity bit), checks parity
// and offers each word on a one-deep valid/ready slot with error statistics.
module parity_checker_rx
  import parity_pkg::*;
#(
  parameter int width = 8,
  parameter int odd   = 0,
  parameter int cnt_w = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  parity_checker_rx_if.slave   bus,
  input  logic                 err_clr,
  output logic [cnt_w-1:0]     err_count,
  output logic                 overrun
);

  localparam int              CW       = $clog2(width + 1);
  localparam logic            ODD_BIT  = (odd != 0) ? PAR_ODD : PAR_EVEN;
  localparam logic [CW-1:0]   LAST_IDX = CW'(width - 1);
  localparam logic [cnt_w-1:0] CNT_MAX = {cnt_w{1'b1}};

  state_t             state_r, state_nxt_s;
  logic [CW-1:0]      cnt_r, cnt_nxt_s;
  logic               xor_r, xor_nxt_s;
  logic [width-1:0]   shift_r, shift_nxt_s;
  logic               out_valid_r, out_valid_nxt_s;
  logic [width-1:0]   out_data_r, out_data_nxt_s;
  logic               out_err_r, out_err_nxt_s;
  logic [cnt_w-1:0]   err_count_r, err_count_nxt_s, err_base_s;
  logic               overrun_r, overrun_nxt_s;
  logic               frame_done_s, slot_free_s, par_err_s;

  // Frame FSM: sof restarts from any state, bits are taken only on bit_valid
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    xor_nxt_s    = xor_r;
    shift_nxt_s  = shift_r;
    frame_done_s = 1'b0;
    if (bus.sof) begin
      state_nxt_s = DATA;
      cnt_nxt_s   = {CW{1'b0}};
      xor_nxt_s   = 1'b0;
    end else if (bus.bit_valid) begin
      case (state_r)
        IDLE: state_nxt_s = IDLE;
        DATA: begin
          for (int i = 0; i < width; i++) begin
            if (cnt_r == CW'(i)) begin
              shift_nxt_s[i] = bus.bit_in;
            end else begin
              shift_nxt_s[i] = shift_r[i];
            end
          end
          xor_nxt_s = xor_r ^ bus.bit_in;
          cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_IDX) begin
            state_nxt_s = PAR;
          end else begin
            state_nxt_s = DATA;
          end
        end
        PAR: begin
          frame_done_s = 1'b1;
          state_nxt_s  = IDLE;
        end
        default: state_nxt_s = IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output slot and status: clear is applied before a same-cycle event
  always_comb begin
    slot_free_s     = !out_valid_r || bus.out_ready;
    par_err_s       = parity_mismatch(xor_r, bus.bit_in, ODD_BIT);
    out_valid_nxt_s = out_valid_r && !bus.out_ready;
    out_data_nxt_s  = out_data_r;
    out_err_nxt_s   = out_err_r;
    err_base_s      = err_clr ? {cnt_w{1'b0}} : err_count_r;
    err_count_nxt_s = err_base_s;
    overrun_nxt_s   = err_clr ? 1'b0 : overrun_r;
    if (frame_done_s && slot_free_s) begin
      out_valid_nxt_s = 1'b1;
      out_data_nxt_s  = shift_r;
      out_err_nxt_s   = par_err_s;
      if (par_err_s && (err_base_s != CNT_MAX)) begin
        err_count_nxt_s = err_base_s + {{(cnt_w-1){1'b0}}, 1'b1};
      end else begin
        err_count_nxt_s = err_base_s;
      end
    end else if (frame_done_s) begin
      overrun_nxt_s = 1'b1;
    end else begin
      overrun_nxt_s = err_clr ? 1'b0 : overrun_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      xor_r       <= 1'b0;
      shift_r     <= {width{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {width{1'b0}};
      out_err_r   <= 1'b0;
      err_count_r <= {cnt_w{1'b0}};
      overrun_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      xor_r       <= xor_nxt_s;
      shift_r     <= shift_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_data_r  <= out_data_nxt_s;
      out_err_r   <= out_err_nxt_s;
      err_count_r <= err_count_nxt_s;
      overrun_r   <= overrun_nxt_s;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_err   = out_err_r;
  assign err_count     = err_count_r;
  assign overrun       = overrun_r;

endmodule

// File: tb/tb_parity_checker_rx.sv
// Directed bench: three receivers (even, odd, 2-bit counter) share one stimulus
// stream; each section checks the instance whose configuration it targets.
module tb_parity_checker_rx;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic err_clr = 1'b0;
  logic sof = 1'b0, bit_valid = 1'b0, bit_in = 1'b0, out_ready = 1'b0;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic ovr_a, ovr_b, ovr_c;
  int n_checks = 0;
  int n_fail = 0;
  int xfers = 0;
  int base;

  always #5 clk = ~clk;

  parity_checker_rx_if #(.width(8)) if_a ();
  parity_checker_rx_if #(.width(8)) if_b ();
  parity_checker_rx_if #(.width(8)) if_c ();

  assign if_a.sof = sof;  assign if_a.bit_valid = bit_valid;  assign if_a.bit_in = bit_in;  assign if_a.out_ready = out_ready;
  assign if_b.sof = sof;  assign if_b.bit_valid = bit_valid;  assign if_b.bit_in = bit_in;  assign if_b.out_ready = out_ready;
  assign if_c.sof = sof;  assign if_c.bit_valid = bit_valid;  assign if_c.bit_in = bit_in;  assign if_c.out_ready = out_ready;

  parity_checker_rx #(.width(8), .odd(0), .cnt_w(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(if_a), .err_clr(err_clr), .err_count(cnt_a), .overrun(ovr_a));
  parity_checker_rx #(.width(8), .odd(1), .cnt_w(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(if_b), .err_clr(err_clr), .err_count(cnt_b), .overrun(ovr_b));
  parity_checker_rx #(.width(8), .odd(0), .cnt_w(2)) dut_c (
    .clk(clk), .reset_n(reset_n), .bus(if_c), .err_clr(err_clr), .err_count(cnt_c), .overrun(ovr_c));

  // Handshake monitor on the even-parity instance
  always @(posedge clk) begin
    if (if_a.out_valid && if_a.out_ready) xfers <= xfers + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       exp_err_a;
    logic [7:0] exp_cnt_a;
    logic       exp_err_b;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic v, input logic b, input logic c);
    @(negedge clk);
    sof = s; bit_valid = v; bit_in = b; err_clr = c;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input bit gaps, input logic clr_par);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, data[i], 1'b0);
    end
    if (gaps) drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, par, clr_par);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    sof = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'd0, 1'b1};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 8'd1, 1'b0};
    vecs[2] = '{8'h11, 1'b0, 1'b0, 8'd1, 1'b1};
    vecs[3] = '{8'h07, 1'b1, 1'b0, 8'd1, 1'b1};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 8'd1, 1'b1};
    vecs[5] = '{8'h01, 1'b0, 1'b1, 8'd2, 1'b0};

    apply_reset();
    chk("rst_valid", 32'(if_a.out_valid), 32'd0);
    chk("rst_data", 32'(if_a.out_data), 32'd0);
    chk("rst_err", 32'(if_a.out_err), 32'd0);
    chk("rst_cnt", 32'(cnt_a), 32'd0);
    chk("rst_ovr", 32'(ovr_a), 32'd0);

    // Table: even and odd sense on the same frames, one-cycle out_valid
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      send_frame(vecs[k].data, vecs[k].par, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("v%0d_valid", k), 32'(if_a.out_valid), 32'd1);
      chk($sformatf("v%0d_data", k), 32'(if_a.out_data), 32'(vecs[k].data));
      chk($sformatf("v%0d_err_even", k), 32'(if_a.out_err), 32'(vecs[k].exp_err_a));
      chk($sformatf("v%0d_cnt", k), 32'(cnt_a), 32'(vecs[k].exp_cnt_a));
      chk($sformatf("v%0d_err_odd", k), 32'(if_b.out_err), 32'(vecs[k].exp_err_b));
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("v%0d_valid_drop", k), 32'(if_a.out_valid), 32'd0);
    end

    // Overrun: slot held by 0x11, 0x22 dropped
    apply_reset();
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_first_valid", 32'(if_a.out_valid), 32'd1);
    chk("ovr_first_flag", 32'(ovr_a), 32'd0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_hold_data", 32'(if_a.out_data), 32'h11);
    chk("ovr_hold_valid", 32'(if_a.out_valid), 32'd1);
    chk("ovr_flag", 32'(ovr_a), 32'd1);
    base = xfers;
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_drain_valid", 32'(if_a.out_valid), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_xfers", 32'(xfers - base), 32'd1);
    chk("ovr_cleared", 32'(ovr_a), 32'd0);

    // Abort by sof after 3 bits, then gappy frame 0x3C
    apply_reset();
    base = xfers;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_valid", 32'(if_a.out_valid), 32'd1);
    chk("abort_data", 32'(if_a.out_data), 32'h3C);
    chk("abort_err", 32'(if_a.out_err), 32'd0);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_xfers", 32'(xfers - base), 32'd1);

    // Saturation on the 2-bit counter, then clear colliding with an error
    apply_reset();
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("sat_cnt%0d", k), 32'(cnt_c), (k > 3) ? 32'd3 : 32'(k));
    end
    chk("nosat_cnt", 32'(cnt_a), 32'd5);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("clr_evt_cnt_c", 32'(cnt_c), 32'd1);
    chk("clr_evt_cnt_a", 32'(cnt_a), 32'd1);

    // Async reset mid-frame with a pending bad word
    out_ready = 1'b0;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) drive(1'b0, 1'b1, 1'b1, 1'b0);
    chk("pre_rst_valid", 32'(if_a.out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(if_a.out_valid), 32'd0);
    chk("arst_data", 32'(if_a.out_data), 32'd0);
    chk("arst_err", 32'(if_a.out_err), 32'd0);
    chk("arst_cnt_a", 32'(cnt_a), 32'd0);
    chk("arst_cnt_c", 32'(cnt_c), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    base = xfers;
    repeat (5) drive(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("stray_valid", 32'(if_a.out_valid), 32'd0);
    chk("stray_xfers", 32'(xfers - base), 32'd0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_valid", 32'(if_a.out_valid), 32'd1);
    chk("post_data", 32'(if_a.out_data), 32'hA5);
    chk("post_err", 32'(if_a.out_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_checker_rx.md
Name: parity_checker_rx

Overview:
Receive-side counterpart of the team's parity generator. Deserialises a framed bit stream (start marker, `width` data bits LSB first, one parity bit) and checks even/odd parity. Presents each received word with an error flag on a valid/ready output. Keeps a saturating parity-error counter and a sticky overrun flag for status readout.

Parameters:
- width, 8, data bits per frame; must be >= 2.
- odd, 0, parity sense: 0 = even (total ones incl. parity bit even), 1 = odd.
- cnt_w, 8, width of err_count.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- sof  input  1  start-of-frame marker; bit_in ignored in a sof cycle.
- bit_valid  input  1  bit_in carries a frame bit this cycle.
- bit_in  input  1  serial data/parity bit.
- out_valid  output  1  out_data/out_err hold a completed frame.
- out_ready  input  1  consumer accepts the frame when out_valid=1.
- out_data  output  width  received word; bit i = i-th data bit received.
- out_err  output  1  parity mismatch on out_data's frame.
- err_count  output  cnt_w  saturating count of frames accepted with parity error.
- overrun  output  1  sticky: a frame was dropped because the output slot was full.
- err_clr  input  1  synchronous clear of err_count and overrun.

Behaviour:
- Reset (reset_n=0, asynchronous): state IDLE, bit counter 0, running XOR 0, shift reg 0, out_valid 0, out_data 0, out_err 0, err_count 0, overrun 0. Frame in progress is discarded.
- States: IDLE, DATA, PAR.
- IDLE: sof=1 -> DATA, counter=0, XOR=0. bit_valid without sof is ignored.
- DATA: on bit_valid, bit_in shifts into position counter of the shift reg, XOR ^= bit_in, counter++. When the width-th bit is taken -> PAR. Idle gaps (bit_valid=0) are allowed anywhere.
- PAR: on bit_valid, err = XOR ^ bit_in ^ odd; state -> IDLE.
  - If the output slot is free (out_valid=0, or out_ready=1 this cycle): load out_data, out_err=err, out_valid=1. If err, err_count increments, saturating at 2^cnt_w-1.
  - Otherwise (out_valid=1 and out_ready=0): frame dropped, overrun set, output registers and err_count unchanged.
- sof in DATA or PAR: current frame aborted without output; restart as from IDLE (counter=0, XOR=0, state DATA).
- Latency: out_valid is high in the cycle after the clock edge that samples the parity bit.
- Output handshake: out_valid falls after a cycle with out_valid&out_ready, unless a new frame loads on that same edge; in that case out_valid stays 1 with the new data.
- out_data/out_err are stable while out_valid=1 and out_ready=0.
- err_clr: err_count and overrun become 0. If an error increment or overrun event coincides with err_clr, the result is err_count=1 or overrun=1 respectively; clear applies first, then the event.
- err_clr does not affect the frame FSM or the output slot.

Decomposition:
- Shared package parity_pkg: state typedef (IDLE/DATA/PAR), parity-sense constants PAR_EVEN=0 / PAR_ODD=1.
- Single module with no sub-module. The running XOR is one register, the shift reg is indexed by the counter, and the counter is $clog2(width+1) bits.

Test Plan:
- Defaults: sof, bits 1,0,1,0,0,1,0,1, parity 0, out_ready=1 -> out_valid one cycle, out_data=0xA5, out_err=0, err_count=0.
- Same frame with parity 1 -> out_data=0xA5, out_err=1, err_count=1. Rerun with odd=1 and parity 1 -> out_err=0.
- out_ready=0, two good frames 0x11 then 0x22 -> out_data stays 0x11, overrun=1. Raise out_ready -> single transfer of 0x11, out_valid then 0. err_clr -> overrun=0.
- sof, 3 bits, sof, then frame 0x3C with parity 0 and random bit_valid gaps -> exactly one output, 0x3C, out_err=0.
- cnt_w=2, five bad-parity frames -> err_count=3 (saturated). err_clr in the cycle a sixth bad frame completes -> err_count=1.
- reset_n low after 4 data bits -> all outputs 0 without a clock edge. After release, stray bit_valid pulses without sof produce no output, and a following full frame 0xA5 is received correctly.
